// File: rtl/sensor_dma_arbiter.sv
// sensor_dma_arbiter
// Shares the single DMEM port between the processor and a sensor snapshot
// engine. When the timer expires or software triggers, the block latches all
// nine 32-bit capacitive readings as one coherent frame. It then writes the
// frame to BASE_ADDR..BASE_ADDR+8, using only cycles the processor leaves free.
//
// Ports
//   clock, reset                : clock, async active-low reset
//   cpu_req/address/data/wren   : processor DMEM request (always has priority)
//   trigger                     : software snapshot request (level, per edge)
//   capacitive_sensor_readings  : channel i at bits [32i+31:32i]
//   address_dmem/d_dmem/wren_dmem : muxed DMEM port (combinational pass-through
//                                   unless the DMA owns the cycle)
//   dma_busy, dma_done          : engine active / one-cycle frame-complete pulse
//   frame_count, overrun_count  : completed frames (wrapping) / dropped
//                                 requests (saturating)
module sensor_dma_arbiter #(
  parameter logic [11:0] BASE_ADDR = 12'd4000,
  parameter int unsigned PERIOD    = 50000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic [11:0]      cpu_address,
  input  logic [31:0]      cpu_data,
  input  logic             cpu_wren,
  input  logic             trigger,
  input  logic [287:0]     capacitive_sensor_readings,
  output logic [11:0]      address_dmem,
  output logic [31:0]      d_dmem,
  output logic             wren_dmem,
  output logic             dma_busy,
  output logic             dma_done,
  output logic [CNT_W-1:0] frame_count,
  output logic [7:0]       overrun_count
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned N_CH   = 9;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned OVR_W  = 8;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(PERIOD - 1);
  localparam logic [OVR_W-1:0] OVR_MAX    = '1;
  localparam bit               TIMER_EN   = (PERIOD != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [N_CH-1:0][WORD_W-1:0]    snap_q, snap_d;
  logic                           pending_q, pending_d;
  logic [CNT_W-1:0]               timer_q, timer_d;
  logic [CNT_W-1:0]               frame_q, frame_d;
  logic [OVR_W-1:0]               overrun_q, overrun_d;

  logic                           timer_expire_c;
  logic                           new_req_c;
  logic                           dma_wr_c;

  // Free-running snapshot timer; held at zero when PERIOD is 0.
  always_comb begin
    timer_expire_c = 1'b0;
    timer_d        = timer_q;
    if (TIMER_EN) begin
      timer_expire_c = (timer_q == TIMER_LAST);
      timer_d        = timer_expire_c ? '0 : CNT_W'(timer_q + 1'b1);
    end
  end

  assign new_req_c = trigger | timer_expire_c;
  // DMA owns the port only in WRITE cycles the processor leaves idle.
  assign dma_wr_c  = (state_q == S_WRITE) && !cpu_req;

  // Next-state and bookkeeping for the snapshot engine.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    pending_d = pending_q;
    frame_d   = frame_q;
    overrun_d = overrun_q;

    // While busy, one request per cycle is either queued or dropped.
    if ((state_q != S_IDLE) && new_req_c) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (overrun_q != OVR_MAX) begin
        overrun_d = overrun_q + 8'd1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (new_req_c || pending_q) begin
          state_d   = S_LATCH;
          pending_d = 1'b0;
        end
      end
      S_LATCH: begin
        snap_d  = capacitive_sensor_readings;
        idx_d   = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (dma_wr_c) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            frame_d = frame_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // A queued request starts the next frame with no IDLE gap.
        if (pending_q) begin
          state_d   = S_LATCH;
          pending_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      pending_q <= 1'b0;
      timer_q   <= '0;
      frame_q   <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      frame_q   <= frame_d;
      overrun_q <= overrun_d;
    end
  end

  // DMEM port mux: processor pass-through keeps its load latency unchanged.
  always_comb begin
    address_dmem = cpu_address;
    d_dmem       = cpu_data;
    wren_dmem    = cpu_wren & cpu_req;
    if (dma_wr_c) begin
      address_dmem = BASE_ADDR + ADDR_W'(idx_q);
      d_dmem       = snap_q[idx_q];
      wren_dmem    = 1'b1;
    end
  end

  assign dma_busy      = (state_q != S_IDLE);
  assign dma_done      = (state_q == S_DONE);
  assign frame_count   = frame_q;
  assign overrun_count = overrun_q;

endmodule

// File: doc/sensor_dma_arbiter.md
# sensor_dma_arbiter

Shares the single data-memory port between the processor and a sensor snapshot engine. Periodically, or on a software trigger, it latches all nine capacitive sensor readings as one coherent 288-bit frame. It then writes the frame into a fixed DMEM window, one word per free cycle. It sits between the processor's DMEM outputs and the `dmem` instance, so game code reads sensor values with ordinary loads.

## Interface

Parameters:
- `BASE_ADDR`, 12'd4000: DMEM word address of channel 0. Channel i goes to `BASE_ADDR+i`. Must satisfy `BASE_ADDR+8 <= 4095`.
- `PERIOD`, 50000: timer period in clocks between automatic snapshots. 0 disables the timer.
- `CNT_W`, 16: width of the timer counter and of `frame_count`. `PERIOD` must be below 2^CNT_W.

Ports (direction, width, meaning):
- `clock`, in, 1: system clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `cpu_req`, in, 1: the processor accesses DMEM this cycle (load or store).
- `cpu_address`, in, 12: processor DMEM address.
- `cpu_data`, in, 32: processor store data.
- `cpu_wren`, in, 1: processor store enable.
- `trigger`, in, 1: software snapshot request, level-sampled each edge.
- `capacitive_sensor_readings`, in, 288: channel i occupies bits [32i+31:32i].
- `address_dmem`, out, 12: to DMEM.
- `d_dmem`, out, 32: to DMEM.
- `wren_dmem`, out, 1: to DMEM.
- `dma_busy`, out, 1: high in the LATCH, WRITE and DONE states.
- `dma_done`, out, 1: one-cycle pulse after a frame is fully written.
- `frame_count`, out, CNT_W: number of completed frames.
- `overrun_count`, out, 8: number of dropped snapshot requests, saturating.

## Operation

- FSM states: IDLE, LATCH, WRITE, DONE.
- **Snapshot request.** `snap_req = trigger | timer_expire | pending`.
- **IDLE.** If `snap_req`, go to LATCH and clear `pending`.
- **LATCH.** Capture all 288 bits of readings into the snapshot register, set `idx=0`, go to WRITE.
- **WRITE, arbitration.** The processor has absolute priority.
  - If `cpu_req=1`, the DMA stalls and `idx` holds.
  - If `cpu_req=0`, the DMA drives `address_dmem=BASE_ADDR+idx`, `d_dmem=snap[32*idx+:32]` and `wren_dmem=1`, then `idx` increments at the edge.
- **WRITE, exit.** When a write with `idx==8` commits, go to DONE and increment `frame_count` (wraps modulo 2^CNT_W).
- **DONE.** `dma_done=1` for one cycle, then go to IDLE.
- **Output mux when the DMA is not writing** (every state except a WRITE cycle with `cpu_req=0`): combinational pass-through.
  - `address_dmem=cpu_address`, `d_dmem=cpu_data`.
  - `wren_dmem=cpu_wren & cpu_req`.
  - Processor load latency is unchanged.
- **Timer.** Free-running counter from 0 to `PERIOD-1`. `timer_expire` pulses for one cycle when the count equals `PERIOD-1`. The timer runs in every state.
- **Request while busy.** A request arriving while not in IDLE sets `pending` if `pending` is clear.
  - If `pending` is already set, the request is dropped and `overrun_count` increments, saturating at 255.
  - A continuously high `trigger` counts once per busy cycle in which it is high.
- **Coherence.** Readings change freely after LATCH. The frame written is exactly the value captured in LATCH.

## Timing

- **Reset (async assert).** State=IDLE; `idx`, snapshot, `pending`, timer, `frame_count` and `overrun_count` all 0; `dma_busy=0`, `dma_done=0`.
  - Other outputs follow the cpu inputs through the pass-through.
  - A frame in progress is abandoned. Words already written stay in DMEM, and no further DMA write occurs.
- **Uncontended latency.** `trigger` sampled at edge k:
  - Edge k+1: latch.
  - Cycles after edges k+1 through k+9: writes of channels 0 through 8.
  - Edge k+10: enter DONE, `frame_count` increments.
  - `dma_done` is high between edges k+10 and k+11.
  - Edge k+11: return to IDLE.
- **Contended latency.** Each cycle with `cpu_req=1` during WRITE adds exactly one cycle. There is no upper bound; starvation under continuous `cpu_req` is accepted.
- **Back-to-back frames.** A pending request starts the next LATCH at the edge leaving DONE, so IDLE lasts 0 cycles.
- **Simultaneous `trigger` and `timer_expire` in IDLE.** One frame, no overrun.

## Test plan

1. **Reset.** Reset low mid-WRITE at `idx=4` -> `dma_busy=0` and `frame_count=0` immediately; no further writes to 4004 through 4008; after release the outputs mirror the cpu inputs.
2. **Uncontended frame.** `PERIOD=0`, channel i = 32'hA0000000+i, one-cycle `trigger` -> nine consecutive writes to 4000 through 4008 with matching data; `dma_done` 10 cycles after the sampling edge; `frame_count=1`.
3. **Contention.** `cpu_req` high on alternate cycles during WRITE -> the cpu address and data appear untouched on those cycles; DMA completes in 18 write-phase cycles; DMEM contents identical to test 2.
4. **Coherence.** Change all readings to 32'hFFFFFFFF one cycle after LATCH -> DMEM still holds the latched values.
5. **Overrun.** Three single-cycle triggers during one frame -> one frame pending, `overrun_count=2`; a second frame starts immediately after DONE; final `frame_count=2`.
6. **Timer.** `PERIOD=100` over 1000 cycles with no cpu traffic -> exactly 10 frames (first `timer_expire` at cycle 99 after reset release); `overrun_count=0`; `frame_count` wraps 65535->0 when preloaded via forced long run.
